// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: sends the first cmd_len entries of a writable command table to a byte UART TX.
// Define UART_CMD_SEQ_AUTO_REPEAT_EN to re-send the frame every REPEAT_CYC cycles after done.
module uart_cmd_seq #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 3,
  parameter int LEN_W       = 4,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 100000,
  parameter int REPEAT_CYC  = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  input  logic              i_tx_done,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_byte_idx,
  output logic              o_done,
  output logic              o_timeout_err
);
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);

  if (DEPTH < 1 || (1 << ADDR_W) < DEPTH || (1 << LEN_W) <= DEPTH || TIMEOUT_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_param
    $error("uart_cmd_seq: inconsistent parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_DONE, S_GAP, S_FINISH
`ifdef UART_CMD_SEQ_AUTO_REPEAT_EN
    , S_HOLD
`endif
  } state_t;

  state_t              r_state, w_state;
  logic [LEN_W-1:0]    r_len, w_len;
  logic [ADDR_W-1:0]   r_idx, w_idx;
  logic [DATA_W-1:0]   r_tx_data, w_tx_data;
  logic                r_tx_valid, w_tx_valid;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic                r_to_err, w_to_err;
  logic [TW-1:0]       r_to_cnt, w_to_cnt;
  logic [GW-1:0]       r_gap_cnt, w_gap_cnt;
  logic [DATA_W-1:0]   r_table [DEPTH];
  logic [LEN_W-1:0]    w_clamp;
  logic [ADDR_W-1:0]   w_idx_inc;
  logic                w_last;
`ifdef UART_CMD_SEQ_AUTO_REPEAT_EN
  localparam int RW = REPEAT_CYC > 1 ? $clog2(REPEAT_CYC) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYC - 1);
  logic [RW-1:0]       r_rep_cnt, w_rep_cnt;
`endif

  assign w_clamp   = (int'(i_cmd_len) > DEPTH) ? LEN_W'(DEPTH) : i_cmd_len;
  assign w_idx_inc = r_idx + ADDR_W'(1);
  assign w_last    = (int'(r_idx) + 1) == int'(r_len);

  assign o_tx_data     = r_tx_data;
  assign o_tx_valid    = r_tx_valid;
  assign o_busy        = r_busy;
  assign o_byte_idx    = r_idx;
  assign o_done        = r_done;
  assign o_timeout_err = r_to_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
    end else if (i_wr_en && !r_busy && int'(i_wr_addr) < DEPTH) begin
      r_table[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_idx      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_to_err   <= 1'b0;
      r_to_cnt   <= '0;
      r_gap_cnt  <= '0;
`ifdef UART_CMD_SEQ_AUTO_REPEAT_EN
      r_rep_cnt  <= '0;
`endif
    end else begin
      r_state    <= w_state;
      r_len      <= w_len;
      r_idx      <= w_idx;
      r_tx_data  <= w_tx_data;
      r_tx_valid <= w_tx_valid;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_to_err   <= w_to_err;
      r_to_cnt   <= w_to_cnt;
      r_gap_cnt  <= w_gap_cnt;
`ifdef UART_CMD_SEQ_AUTO_REPEAT_EN
      r_rep_cnt  <= w_rep_cnt;
`endif
    end
  end

  always_comb begin
    w_state    = r_state;
    w_len      = r_len;
    w_idx      = r_idx;
    w_tx_data  = r_tx_data;
    w_tx_valid = r_tx_valid;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_to_err   = 1'b0;
    w_to_cnt   = r_to_cnt;
    w_gap_cnt  = r_gap_cnt;
`ifdef UART_CMD_SEQ_AUTO_REPEAT_EN
    w_rep_cnt  = r_rep_cnt;
`endif
    case (r_state)
      // r_done blocks a start arriving on the done cycle
      S_IDLE: if (i_start && !r_done) begin
        w_len      = w_clamp;
        w_busy     = 1'b1;
        w_idx      = '0;
        w_state    = (w_clamp == '0) ? S_FINISH : S_SEND;
        w_tx_data  = (w_clamp == '0) ? r_tx_data : r_table[0];
        w_tx_valid = (w_clamp != '0);
      end
      S_SEND: if (i_tx_ready) begin
        w_tx_valid = 1'b0;
        w_to_cnt   = '0;
        w_state    = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (i_tx_done) begin
        if (w_last) w_state = S_FINISH;
        else begin
          w_idx      = w_idx_inc;
          w_gap_cnt  = '0;
          w_state    = (GAP_CYC == 0) ? S_SEND : S_GAP;
          w_tx_data  = (GAP_CYC == 0) ? r_table[w_idx_inc] : r_tx_data;
          w_tx_valid = (GAP_CYC == 0);
        end
      end else if (r_to_cnt == T_LAST) begin
        w_to_err = 1'b1;
        w_busy   = 1'b0;
        w_idx    = '0;
        w_state  = S_IDLE;
      end else w_to_cnt = r_to_cnt + TW'(1);
      S_GAP: if (r_gap_cnt == G_LAST) begin
        w_state    = S_SEND;
        w_tx_data  = r_table[r_idx];
        w_tx_valid = 1'b1;
      end else w_gap_cnt = r_gap_cnt + GW'(1);
      S_FINISH: begin
        w_done = 1'b1;
        w_busy = 1'b0;
        w_idx  = '0;
`ifdef UART_CMD_SEQ_AUTO_REPEAT_EN
        w_state   = S_HOLD;
        w_rep_cnt = '0;
`else
        w_state = S_IDLE;
`endif
      end
`ifdef UART_CMD_SEQ_AUTO_REPEAT_EN
      // HOLD starts on the done cycle, so the resend lands REPEAT_CYC cycles after done
      S_HOLD: if (r_rep_cnt == R_LAST) begin
        w_busy     = 1'b1;
        w_idx      = '0;
        w_state    = (r_len == '0) ? S_FINISH : S_SEND;
        w_tx_data  = (r_len == '0) ? r_tx_data : r_table[0];
        w_tx_valid = (r_len != '0);
      end else w_rep_cnt = r_rep_cnt + RW'(1);
`endif
      default: w_state = S_IDLE;
    endcase
  end
endmodule

// File: doc/uart_cmd_seq.md
Name: uart_cmd_seq

Overview:
- Parametrised command-frame sequencer that feeds a byte-wide UART transmitter. Typical frames are sensor configuration/query commands such as A5 54 / A5 52.
- Holds a runtime-writable command table and, on a start pulse, sends the first cmd_len entries in order.
- Uses a valid/ready handshake toward the UART TX, waits for the per-byte tx_done, and inserts a programmable inter-byte gap.
- Replaces hard-coded one-shot counters with timeout detection and an optional periodic re-send (query mode).

Parameters:
- DATA_W, 8, byte width of each table entry and of tx_data.
- DEPTH, 8, number of command table entries. Must be ≥1.
- ADDR_W, 3, table address width. Must satisfy 2**ADDR_W ≥ DEPTH.
- LEN_W, 4, width of cmd_len. Must represent DEPTH.
- GAP_CYC, 16, idle clk cycles between tx_done and presenting the next byte. 0 means no gap.
- TIMEOUT_CYC, 100000, maximum cycles spent in WAIT_DONE before abort.
- REPEAT_CYC, 1000000, re-send period; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a frame when idle
- cmd_len  in  LEN_W  number of bytes to send; sampled on an accepted start
- wr_en  in  1  command table write strobe
- wr_addr  in  ADDR_W  table write address
- wr_data  in  DATA_W  table write data
- tx_data  out  DATA_W  byte presented to the UART TX
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  UART TX accepts the byte when tx_valid && tx_ready
- tx_done  in  1  single-cycle pulse; UART finished shifting the byte out
- busy  out  1  a frame is in progress
- byte_idx  out  ADDR_W  index of the current byte
- done  out  1  single-cycle pulse; frame completed
- timeout_err  out  1  single-cycle pulse; frame aborted

Behaviour:
- Reset is asynchronous. On reset: tx_data=0, tx_valid=0, busy=0, byte_idx=0, done=0, timeout_err=0, all table entries=0, state=IDLE, all counters=0.
- Table writes: on a rising edge with wr_en=1 and busy=0, table[wr_addr] ← wr_data. Writes are ignored while busy=1 and when wr_addr ≥ DEPTH.
- Length: len_q ← min(cmd_len, DEPTH), latched on the cycle start is accepted.
- States are IDLE, SEND, WAIT_DONE, GAP, FINISH.
- IDLE:
  - start=1 with a clamped length of 0 → FINISH directly; no byte is sent.
  - start=1 with length >0 → SEND. busy=1, byte_idx=0, tx_data=table[0], tx_valid=1, all from the next cycle (latency 1).
  - start is ignored in every state other than IDLE.
- SEND:
  - tx_valid and tx_data stay stable until the edge where tx_ready=1.
  - On that edge: tx_valid←0, clear the timeout counter, go to WAIT_DONE.
  - tx_done pulses that arrive in SEND are ignored.
- WAIT_DONE:
  - tx_done=1 and byte_idx==len_q-1 → FINISH.
  - tx_done=1 otherwise → byte_idx+1, then GAP (or SEND directly when GAP_CYC=0).
  - The timeout counter increments every cycle. When it reaches TIMEOUT_CYC-1 without a tx_done: timeout_err=1 for one cycle, busy←0, byte_idx←0, state→IDLE.
  - If tx_done and the timeout hit fall on the same cycle, tx_done wins.
- GAP: counts GAP_CYC cycles, then → SEND with tx_data=table[byte_idx] and tx_valid=1.
- FINISH: done=1 for exactly one cycle, busy←0, byte_idx←0, then → IDLE. A start on the done cycle is ignored.
- Counters are sized with $clog2 of their limit and saturate; they never wrap.
- Reset mid-frame: tx_valid drops immediately (asynchronously); no done or timeout_err pulse is produced.

Optional Feature:
- Macro: UART_CMD_SEQ_AUTO_REPEAT_EN.
- Defined: after FINISH the block enters an extra HOLD state (busy=0) and counts REPEAT_CYC cycles from the done pulse, then re-sends the frame using the latched len_q, as if start had been pulsed.
  - A start during HOLD is ignored; the repeat is not restarted.
  - A timeout_err in any frame cancels repeating until the next external start.
- Undefined: one-shot only; FINISH → IDLE. The HOLD state and its counter are not synthesised.

Test Plan:
1. Write table {A5,54,A5,52}, cmd_len=4, tx_ready=1 tied, tx_done 10 cycles after each accept, GAP_CYC=16 → tx_data sequence A5,54,A5,52, each preceded by a 1-cycle tx_valid; exactly one done pulse; busy high from start+1 to the done cycle.
2. Hold tx_ready=0 for 5 cycles → tx_valid and tx_data (A5) stay stable for all 5 cycles; accept happens on the first ready cycle; no byte is skipped or duplicated.
3. cmd_len=0 → done pulses 2 cycles after start, tx_valid never rises. cmd_len=12 with DEPTH=8 → exactly 8 bytes sent.
4. Never pulse tx_done, TIMEOUT_CYC=50 → timeout_err pulses 50 cycles after accept, state returns to IDLE, no done pulse; a following start sends the frame normally.
5. Assert rst_n=0 during GAP of byte 2, then start again → outputs zero immediately; table cleared to 0; the new frame sends 00 bytes.
6. With UART_CMD_SEQ_AUTO_REPEAT_EN, REPEAT_CYC=200, 2-byte frame → second frame begins 200 cycles after the first done, repeating continuously; a timeout stops the repetition.
